sdram_arbiter: RTL and testbench

- Shares one edge-triggered sdram controller port (rd/we strobes, ready, 27-bit byte address, 16-bit data, 2-bit wtbt) among N requesters.
- Requesters use a level req / single-cycle ack handshake.
- Sits between the sdram controller and the CPU, video and loader clients of the menu core.
- Arbitrates round-robin or fixed priority, turns grants into one-cycle strobes, holds address and data stable, and returns read data with the ack.

---
 rtl/sdram_arb_pkg.sv | 21 ++
 rtl/sdram_arbiter_rr_pick.sv | 28 ++
 rtl/sdram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the sdram port arbiter and its pickers.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BLANK,
        WAIT,
        DONE
    } state_t;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 16;
    localparam int WTBT_W = 2;

    // Low bit of element idx in a packed bus of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational requester picker: round-robin after ptr, or lowest index when fixed.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             fixed,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        if (fixed) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[IDX_W'(i)]) idx = IDX_W'(i);
            end
        end else begin
            // Walk the search order backwards so the nearest candidate after ptr wins.
            for (int k = N; k >= 1; k--) begin
                if (req[IDX_W'((int'(ptr) + k) % N)]) idx = IDX_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one sdram controller port among N level-request clients with one-cycle acks.
//
// state | meaning
// IDLE  | wait for controller ready and any request, then grant and strobe
// ISSUE | rd/we strobe high for this single cycle
// BLANK | controller ready ignored while its registered ready drop settles
// WAIT  | wait for ready (or timeout), then capture data and ack
// DONE  | ack high for this single cycle
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int N          = 3,
    parameter int FIXED_PRIO = 0,
    parameter int BLANK_CYC  = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req_rd,
    input  logic [N-1:0]        req_we,
    input  logic [N*ADDR_W-1:0] req_addr,
    input  logic [N*DATA_W-1:0] req_din,
    input  logic [N*WTBT_W-1:0] req_wtbt,
    output logic [N-1:0]        req_ack,
    output logic [DATA_W-1:0]   req_dout,
    output logic                req_err,
    output logic [ADDR_W-1:0]   sd_addr,
    output logic [DATA_W-1:0]   sd_din,
    output logic [WTBT_W-1:0]   sd_wtbt,
    output logic                sd_rd,
    output logic                sd_we,
    input  logic                sd_ready,
    input  logic [DATA_W-1:0]   sd_dout
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int BLK_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state;
    logic [IDX_W-1:0] g;
    logic [IDX_W-1:0] ptr;
    logic             op_we;
    logic [BLK_W-1:0] blk_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic [N-1:0]      req_any;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [N-1:0]      ack_vec;
    logic [ADDR_W-1:0] addr_sl [N];
    logic [DATA_W-1:0] din_sl  [N];
    logic [WTBT_W-1:0] wtbt_sl [N];

    assign req_any = req_rd | req_we;
    assign ack_vec = {{(N-1){1'b0}}, 1'b1} << g;

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign addr_sl[i] = req_addr[slice_lo(i, ADDR_W) +: ADDR_W];
        assign din_sl[i]  = req_din[slice_lo(i, DATA_W) +: DATA_W];
        assign wtbt_sl[i] = req_wtbt[slice_lo(i, WTBT_W) +: WTBT_W];
    end

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_any),
        .ptr   (ptr),
        .fixed (FIXED_PRIO != 0),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            g        <= '0;
            ptr      <= IDX_W'(N - 1);
            op_we    <= 1'b0;
            blk_cnt  <= '0;
            tmo_cnt  <= '0;
            req_ack  <= '0;
            req_dout <= '0;
            req_err  <= 1'b0;
            sd_addr  <= '0;
            sd_din   <= '0;
            sd_wtbt  <= '0;
            sd_rd    <= 1'b0;
            sd_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sd_ready && pick_valid) begin
                        g       <= pick_idx;
                        ptr     <= pick_idx;
                        sd_addr <= addr_sl[pick_idx];
                        sd_din  <= din_sl[pick_idx];
                        sd_wtbt <= wtbt_sl[pick_idx];
                        op_we   <= req_we[pick_idx];
                        sd_we   <= req_we[pick_idx];
                        sd_rd   <= ~req_we[pick_idx];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    sd_rd <= 1'b0;
                    sd_we <= 1'b0;
                    if (BLANK_CYC == 0) begin
                        tmo_cnt <= TMO_W'(TIMEOUT - 1);
                        state   <= WAIT;
                    end else begin
                        blk_cnt <= BLK_W'(BLANK_CYC);
                        state   <= BLANK;
                    end
                end
                BLANK: begin
                    blk_cnt <= blk_cnt - 1'b1;
                    if (blk_cnt <= BLK_W'(1)) begin
                        tmo_cnt <= TMO_W'(TIMEOUT - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (sd_ready) begin
                        if (!op_we) req_dout <= sd_dout;
                        req_ack <= ack_vec;
                        state   <= DONE;
                    end else if (tmo_cnt == '0) begin
                        req_err <= 1'b1;
                        req_ack <= ack_vec;
                        state   <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                DONE: begin
                    req_ack <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: round-robin and fixed-priority instances, each behind a controller model.
module tb_sdram_arbiter;

    localparam int N   = 3;
    localparam int TMO = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, model_rst;
    logic [N-1:0]    req_rd [2], req_we [2], req_ack [2];
    logic [N*27-1:0] req_addr [2];
    logic [N*16-1:0] req_din [2];
    logic [N*2-1:0]  req_wtbt [2];
    logic [15:0]     req_dout [2], sd_din [2], sd_dout [2];
    logic            req_err [2], sd_rd [2], sd_we [2], sd_ready [2];
    logic [26:0]     sd_addr [2];
    logic [1:0]      sd_wtbt [2];
    bit              hold [2];
    int              stretch [2];
    bit              rand_stretch;

    int total = 0;
    int bad   = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        sdram_arbiter #(.N(N), .FIXED_PRIO(gi), .BLANK_CYC(2), .TIMEOUT(TMO)) dut (
            .clk(clk), .reset(reset),
            .req_rd(req_rd[gi]), .req_we(req_we[gi]), .req_addr(req_addr[gi]),
            .req_din(req_din[gi]), .req_wtbt(req_wtbt[gi]),
            .req_ack(req_ack[gi]), .req_dout(req_dout[gi]), .req_err(req_err[gi]),
            .sd_addr(sd_addr[gi]), .sd_din(sd_din[gi]), .sd_wtbt(sd_wtbt[gi]),
            .sd_rd(sd_rd[gi]), .sd_we(sd_we[gi]), .sd_ready(sd_ready[gi]), .sd_dout(sd_dout[gi])
        );

        // Controller model: ready drops after it takes a strobe, returns 1+stretch cycles later.
        logic [15:0] mem [128];
        logic [15:0] dout_r;
        logic        rdy;
        int          cnt;
        always @(posedge clk) begin
            if (model_rst) begin
                for (int a = 0; a < 128; a++) mem[a] <= 16'h0;
                rdy    <= 1'b1;
                cnt    <= 0;
                dout_r <= 16'h0;
            end else if (sd_rd[gi] || sd_we[gi]) begin
                if (sd_we[gi]) begin
                    if (sd_wtbt[gi][0]) mem[sd_addr[gi][7:1]][7:0]  <= sd_din[gi][7:0];
                    if (sd_wtbt[gi][1]) mem[sd_addr[gi][7:1]][15:8] <= sd_din[gi][15:8];
                end else begin
                    dout_r <= mem[sd_addr[gi][7:1]];
                end
                rdy <= 1'b0;
                cnt <= 1 + (rand_stretch ? int'($urandom_range(0, 3)) : stretch[gi]);
            end else if (!rdy) begin
                if (cnt == 0) rdy <= 1'b1;
                else cnt <= cnt - 1;
            end
        end
        assign sd_ready[gi] = rdy & ~hold[gi];
        assign sd_dout[gi]  = dout_r;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int k, input int i, input bit rd, input bit we,
                           input logic [26:0] a, input logic [15:0] d, input logic [1:0] bt);
        req_rd[k][i] = rd;
        req_we[k][i] = we;
        req_addr[k][27*i +: 27] = a;
        req_din[k][16*i +: 16]  = d;
        req_wtbt[k][2*i +: 2]   = bt;
    endtask

    task automatic wait_strobe(input int k, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sd_rd[k] || sd_we[k]) && n < maxc);
    endtask

    task automatic wait_ack(input int k, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ack[k] == '0 && n < maxc);
    endtask

    task automatic onehot(input int i, output logic [N-1:0] oh);
        oh = '0;
        oh[i] = 1'b1;
    endtask

    // Full single-requester transaction on instance 0, request dropped at ack.
    task automatic single_txn(input string name, input int i, input bit rd, input bit we,
                              input logic [26:0] a, input logic [15:0] d, input logic [1:0] bt,
                              input int exp_lat, input logic [15:0] exp_dout);
        int n, lat;
        bit stable;
        logic [26:0] a0;
        logic [N-1:0] oh;
        set_req(0, i, rd, we, a, d, bt);
        wait_strobe(0, 400, n);
        chk({name, "_strobe"}, {sd_we[0], sd_rd[0]}, we ? 2'b10 : 2'b01);
        chk({name, "_bus"}, {sd_addr[0], sd_din[0], sd_wtbt[0]}, {a, d, bt});
        a0 = sd_addr[0];
        stable = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (sd_addr[0] != a0 || sd_rd[0] || sd_we[0]) stable = 1'b0;
        end while (req_ack[0] == '0 && lat < 100);
        onehot(i, oh);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_ack"}, req_ack[0], oh);
        chk({name, "_dout"}, req_dout[0], exp_dout);
        chk({name, "_hold"}, stable, 1'b1);
        set_req(0, i, 1'b0, 1'b0, 27'h0, 16'h0, 2'b00);
    endtask

    typedef struct {
        int          req;
        bit          rd;
        bit          we;
        logic [26:0] addr;
        logic [15:0] din;
        logic [1:0]  wtbt;
        logic [15:0] dout;
    } vec_t;

    vec_t        tbl [8];
    logic [15:0] ref_mem [128];

    initial begin
        int n, acks, w, rptr, owner, wait_cnt, ngrant;
        bit outst, owner_we;
        logic [26:0] o_addr;
        logic [15:0] o_din, d_hold;
        logic [1:0]  o_bt;
        logic [N-1:0] oh;

        tbl[0] = '{0, 1'b0, 1'b1, 27'h0000010, 16'hA55A, 2'b11, 16'h0000};
        tbl[1] = '{0, 1'b1, 1'b0, 27'h0000010, 16'h0F0F, 2'b00, 16'hA55A};
        tbl[2] = '{1, 1'b0, 1'b1, 27'h0000010, 16'h1234, 2'b01, 16'hA55A};
        tbl[3] = '{2, 1'b1, 1'b0, 27'h0000010, 16'h0000, 2'b11, 16'hA534};
        tbl[4] = '{2, 1'b0, 1'b1, 27'h7FFFFFE, 16'hBEEF, 2'b10, 16'hA534};
        tbl[5] = '{1, 1'b1, 1'b0, 27'h7FFFFFE, 16'h5555, 2'b01, 16'hBE00};
        tbl[6] = '{0, 1'b1, 1'b1, 27'h0000020, 16'hC3C3, 2'b11, 16'hBE00};
        tbl[7] = '{0, 1'b1, 1'b0, 27'h0000020, 16'h0000, 2'b11, 16'hC3C3};

        for (int k = 0; k < 2; k++) begin
            req_rd[k] = '0; req_we[k] = '0; req_addr[k] = '0; req_din[k] = '0; req_wtbt[k] = '0;
            hold[k] = 1'b0; stretch[k] = 0;
        end
        rand_stretch = 1'b0;
        reset = 1'b1;
        model_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset_outputs_%0d", k),
                {sd_rd[k], sd_we[k], req_ack[k], req_err[k], sd_addr[k], sd_din[k], sd_wtbt[k], req_dout[k]}, 64'h0);
        reset = 1'b0;
        model_rst = 1'b0;

        for (int v = 0; v < 8; v++)
            single_txn($sformatf("vec%0d", v), tbl[v].req, tbl[v].rd, tbl[v].we, tbl[v].addr,
                       tbl[v].din, tbl[v].wtbt, 4, tbl[v].dout);

        // Round-robin fairness from a fresh pointer with all three reading continuously.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(0, i, 1'b1, 1'b0, 27'h40 + 27'(2 * i), 16'h0, 2'b11);
        for (int t = 0; t < 9; t++) begin
            n = 0;
            acks = 0;
            do begin
                @(negedge clk);
                n++;
                if (req_ack[0] != '0) acks++;
            end while (!(sd_rd[0] || sd_we[0]) && n < 100);
            chk($sformatf("rr_order_%0d", t), sd_addr[0], 27'h40 + 27'(2 * (t % 3)));
            if (t > 0) begin
                chk($sformatf("rr_gap_%0d", t), 64'(n), 64'd6);
                chk($sformatf("rr_acks_%0d", t), 64'(acks), 64'd1);
            end
        end
        wait_ack(0, 50, n);
        onehot(2, oh);
        chk("rr_last_ack", req_ack[0], oh);
        for (int i = 0; i < N; i++) set_req(0, i, 1'b0, 1'b0, 27'h0, 16'h0, 2'b00);

        // Controller startup: nothing may be issued while ready is low.
        hold[0] = 1'b1;
        set_req(0, 1, 1'b1, 1'b0, 27'h0000020, 16'h0, 2'b11);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (sd_rd[0] || sd_we[0]) n++;
        end
        chk("startup_no_strobe", 64'(n), 64'd0);
        hold[0] = 1'b0;
        stretch[0] = 9;
        single_txn("refresh_stretch", 1, 1'b1, 1'b0, 27'h0000020, 16'h0, 2'b11, 13, 16'hC3C3);
        stretch[0] = 0;

        // Timeout: ready never returns during WAIT.
        set_req(0, 2, 1'b1, 1'b0, 27'h0000010, 16'h0, 2'b11);
        wait_strobe(0, 50, n);
        hold[0] = 1'b1;
        wait_ack(0, 100, n);
        onehot(2, oh);
        chk("tmo_lat", 64'(n), 64'(1 + 2 + TMO));
        chk("tmo_ack", req_ack[0], oh);
        chk("tmo_err", req_err[0], 1'b1);
        chk("tmo_dout_kept", req_dout[0], 16'hC3C3);
        set_req(0, 2, 1'b0, 1'b0, 27'h0, 16'h0, 2'b00);
        hold[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("tmo_err_sticky", req_err[0], 1'b1);
        single_txn("after_tmo", 2, 1'b1, 1'b0, 27'h0000010, 16'h0, 2'b11, 4, 16'hA534);
        chk("tmo_err_sticky2", req_err[0], 1'b1);

        // Asynchronous reset while in BLANK.
        set_req(0, 0, 1'b1, 1'b0, 27'h0000020, 16'h0, 2'b11);
        wait_strobe(0, 50, n);
        @(posedge clk);
        #1;
        hold[0] = 1'b1;
        reset = 1'b1;
        #1;
        chk("areset_clear", {sd_rd[0], sd_we[0], req_ack[0], req_err[0]}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sd_rd[0] || sd_we[0]) n++;
            if (req_ack[0] != '0) acks++;
        end
        chk("areset_no_grant", 64'(n), 64'd0);
        chk("areset_no_ack", 64'(acks), 64'd0);
        hold[0] = 1'b0;
        single_txn("areset_regrant", 0, 1'b1, 1'b0, 27'h0000020, 16'h0, 2'b11, 4, 16'hC3C3);

        // Fixed priority: req0 wins while pending, req2 right after req0 drops.
        set_req(1, 0, 1'b1, 1'b0, 27'h50, 16'h0, 2'b11);
        set_req(1, 2, 1'b1, 1'b0, 27'h60, 16'h0, 2'b11);
        for (int t = 0; t < 3; t++) begin
            wait_strobe(1, 50, n);
            chk($sformatf("fp_req0_%0d", t), sd_addr[1], 27'h50);
            wait_ack(1, 50, n);
            onehot(0, oh);
            chk($sformatf("fp_ack0_%0d", t), req_ack[1], oh);
        end
        set_req(1, 0, 1'b0, 1'b0, 27'h0, 16'h0, 2'b00);
        wait_strobe(1, 50, n);
        chk("fp_req2_first_idle", 64'(n), 64'd2);
        chk("fp_req2_addr", sd_addr[1], 27'h60);
        wait_ack(1, 50, n);
        onehot(2, oh);
        chk("fp_ack2", req_ack[1], oh);
        set_req(1, 2, 1'b0, 1'b0, 27'h0, 16'h0, 2'b00);

        // Random traffic against a transaction-level reference.
        reset = 1'b1;
        model_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_rst = 1'b0;
        rand_stretch = 1'b1;
        for (int a = 0; a < 128; a++) ref_mem[a] = 16'h0;
        rptr = N - 1;
        outst = 1'b0;
        owner = 0;
        owner_we = 1'b0;
        o_addr = '0; o_din = '0; o_bt = '0;
        wait_cnt = 0;
        ngrant = 0;
        for (int cyc = 0; cyc < 3400; cyc++) begin
            @(negedge clk);
            if (sd_rd[0] || sd_we[0]) begin
                w = -1;
                for (int s = 1; s <= N; s++) begin
                    if (req_rd[0][(rptr + s) % N] || req_we[0][(rptr + s) % N]) begin
                        w = (rptr + s) % N;
                        break;
                    end
                end
                chk("rnd_grant_valid", {outst, w >= 0}, 2'b01);
                if (w >= 0) begin
                    owner_we = req_we[0][w];
                    o_addr = req_addr[0][27*w +: 27];
                    o_din  = req_din[0][16*w +: 16];
                    o_bt   = req_wtbt[0][2*w +: 2];
                    chk("rnd_grant", {sd_we[0], sd_rd[0], sd_addr[0], sd_din[0], sd_wtbt[0]},
                        {owner_we, ~owner_we, o_addr, o_din, o_bt});
                    rptr = w;
                    owner = w;
                end
                outst = 1'b1;
                wait_cnt = 0;
                ngrant++;
            end
            if (req_ack[0] != '0) begin
                onehot(owner, oh);
                chk("rnd_ack", {outst, req_ack[0]}, {1'b1, oh});
                if (owner_we) begin
                    d_hold = ref_mem[o_addr[7:1]];
                    if (o_bt[0]) d_hold[7:0]  = o_din[7:0];
                    if (o_bt[1]) d_hold[15:8] = o_din[15:8];
                    ref_mem[o_addr[7:1]] = d_hold;
                    req_we[0][owner] = 1'b0;
                end else begin
                    chk("rnd_dout", req_dout[0], ref_mem[o_addr[7:1]]);
                    req_rd[0][owner] = 1'b0;
                end
                outst = 1'b0;
            end
            if (outst) begin
                wait_cnt++;
                if (wait_cnt > 40) begin
                    chk("rnd_stall", 64'(wait_cnt), 64'd40);
                    outst = 1'b0;
                end
            end
            if (cyc < 3000) begin
                for (int i = 0; i < N; i++) begin
                    if (!(req_rd[0][i] || req_we[0][i]) && $urandom_range(0, 3) == 0) begin
                        n = int'($urandom_range(0, 2));
                        set_req(0, i, n != 1, n != 0,
                                {$urandom_range(0, 32'h7FFFF) , 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1))},
                                16'($urandom), 2'($urandom_range(0, 3)));
                    end
                end
            end
        end
        chk("rnd_drained", {outst, req_rd[0] | req_we[0]}, 64'h0);
        chk("rnd_activity", ngrant > 200, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
